imu_burst_ctrl: RTL and testbench
=================================

IMU_BURST_CTRL -- requirements
Module: imu_burst_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, sample width.
REQ-002 SHALL have parameter BURST_LEN, default 16, samples per burst (>=2).
REQ-003 SHALL have parameter PERIOD_W, default 16, width of the period register.
REQ-004 SHALL use one clock and an asynchronous, active-high reset.
REQ-005 SHALL have port clk, input, 1, the single clock; all state on its rising edge.
REQ-006 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port start, input, 1, one-cycle request to begin periodic bursts.
REQ-008 SHALL have port stop, input, 1, one-cycle request to end periodic bursts.
REQ-009 SHALL have port period, input, PERIOD_W, cycles from one burst start to the next, sampled at each burst start.
REQ-010 SHALL have port gen_enable, output, 1, registered enable to the IMU sample generator.
REQ-011 SHALL have port gen_data, input, DATA_WIDTH, generator sample.
REQ-012 SHALL have port gen_valid, input, 1, generator sample qualifier.
REQ-013 SHALL have port out_data, output, DATA_WIDTH, sample to the fusion datapath.
REQ-014 SHALL have port out_valid, output, 1, out_data valid.
REQ-015 SHALL have port out_ready, input, 1, downstream accept.
REQ-016 SHALL have port out_last, output, 1, marks the BURST_LEN-th sample of a burst.
REQ-017 SHALL have port busy, output, 1, high whenever the FSM is not IDLE.
REQ-018 SHALL have port frame_cnt, output, 8, completed bursts, wraps 255->0.

Function
REQ-019 SHALL implement FSM states IDLE, BURST, WAIT; gen_enable=1 only in BURST.
REQ-020 SHALL, in IDLE with start=1 and stop=0, enter BURST next cycle and load the period timer with period-1 (period 0 treated as 1).
REQ-021 SHALL decrement the period timer every cycle outside IDLE, saturating at 0.
REQ-022 SHALL, in BURST, count every cycle with gen_valid=1 as one burst sample, whether buffered or dropped.
REQ-023 SHALL, on the cycle the BURST_LEN-th sample is counted, increment frame_cnt, clear the sample count, and enter WAIT.
REQ-024 SHALL, in WAIT with timer 0 and no pending stop, enter BURST and reload the timer; a burst longer than period yields one WAIT cycle before the next BURST.
REQ-025 SHALL latch stop into a pending flag; in WAIT, a pending stop enters IDLE next cycle; in BURST, the burst completes, then goes to IDLE instead of WAIT.
REQ-026 SHALL give stop priority when start and stop are both high; start outside IDLE is ignored; the pending flag clears on entering IDLE.
REQ-027 SHALL ignore gen_valid outside BURST (not buffered, not counted).
REQ-028 SHALL buffer samples in a 2-entry FIFO with out_data/out_last driven from the head; a sample accepted at cycle N is visible at cycle N+1 earliest.
REQ-029 SHALL pop on out_valid&&out_ready; out_valid/out_data/out_last held stable until popped.
REQ-030 SHALL drop a sample arriving while the FIFO is full and not popping that cycle; a simultaneous pop frees space and the sample is accepted.

Reset
REQ-031 SHALL, while rst=1, force FSM IDLE, timer 0, sample count 0, FIFO empty, pending stop 0, gen_enable 0, out_valid 0, out_data 0, out_last 0, busy 0, frame_cnt 0 (and ovf_cnt 0 when present).
REQ-032 SHALL discard a burst in progress and any buffered samples on reset assertion mid-operation.

Configuration
REQ-033 SHALL, with macro IMU_BURST_CTRL_OVF_CNT_EN defined, add output ovf_cnt, 8, counting dropped samples, saturating at 255, cleared only by reset.
REQ-034 SHALL, without IMU_BURST_CTRL_OVF_CNT_EN, omit port ovf_cnt and its logic; drop behaviour is otherwise identical.

Verification
REQ-035 SHALL cover: period=40, start, generator valid every cycle, out_ready=1 -> 16 samples per burst, out_last on the 16th, bursts start 40 cycles apart, frame_cnt 1,2,3.
REQ-036 SHALL cover: period=4 (shorter than burst) -> each BURST followed by exactly one WAIT cycle, then BURST.
REQ-037 SHALL cover: out_ready=0 for a whole burst, macro defined -> 2 samples held, 14 dropped, ovf_cnt=14, out_last not delivered, frame_cnt still increments.
REQ-038 SHALL cover: stop at burst sample 5 -> burst completes all 16 samples, then IDLE, busy=0; stop during WAIT -> IDLE next cycle.
REQ-039 SHALL cover: start and stop same cycle in IDLE -> remains IDLE, gen_enable=0.
REQ-040 SHALL cover: rst pulse at burst sample 8 with FIFO full -> all outputs at reset values during rst; after release, remains IDLE until next start.

Source files
------------

// File: rtl/imu_burst_ctrl.sv
// Periodic IMU burst controller: gates the sample generator in fixed-length bursts and
// buffers samples in a 2-entry FIFO. Define IMU_BURST_CTRL_OVF_CNT_EN to add the ovf_cnt output.
module imu_burst_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int BURST_LEN  = 16,
    parameter int PERIOD_W   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  stop,
    input  logic [PERIOD_W-1:0]   period,
    output logic                  gen_enable,
    input  logic [DATA_WIDTH-1:0] gen_data,
    input  logic                  gen_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  busy,
    output logic [7:0]            frame_cnt
`ifdef IMU_BURST_CTRL_OVF_CNT_EN
    ,
    output logic [7:0]            ovf_cnt
`endif
);

    localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BURST_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BURST,
        S_WAIT
    } state_e;

    state_e                state_q, state_d;
    logic [PERIOD_W-1:0]   timer_q, timer_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  pend_q, pend_d;
    logic [7:0]            frame_q, frame_d;
    logic                  gen_en_q;

    logic [DATA_WIDTH-1:0] data_q [2];
    logic [1:0]            last_q;
    logic                  wr_q, rd_q;
    logic [1:0]            fcnt_q, fcnt_d;

    logic                  stop_eff;
    logic [PERIOD_W-1:0]   reload;
    logic                  sample;
    logic                  burst_done;
    logic                  pop;
    logic                  push;

    // A stop seen this cycle acts immediately, as if it had already been latched.
    assign stop_eff   = pend_q | stop;
    assign reload     = (period == '0) ? '0 : period - PERIOD_W'(1);
    assign sample     = (state_q == S_BURST) && gen_valid;
    assign burst_done = sample && (cnt_q == LAST_IDX);
    assign pop        = out_valid && out_ready;
    assign push       = sample && ((fcnt_q != 2'd2) || pop);

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        cnt_d   = cnt_q;
        frame_d = frame_q;

        if ((state_q != S_IDLE) && (timer_q != '0)) begin
            timer_d = timer_q - PERIOD_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (start && !stop) begin
                    state_d = S_BURST;
                    timer_d = reload;
                end
            end
            S_BURST: begin
                if (burst_done) begin
                    cnt_d   = '0;
                    frame_d = frame_q + 8'd1;
                    state_d = stop_eff ? S_IDLE : S_WAIT;
                end else if (sample) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WAIT: begin
                if (stop_eff) begin
                    state_d = S_IDLE;
                end else if (timer_q == '0) begin
                    state_d = S_BURST;
                    timer_d = reload;
                end
            end
            default: state_d = S_IDLE;
        endcase

        pend_d = (state_d == S_IDLE) ? 1'b0 : stop_eff;

        case ({push, pop})
            2'b10:   fcnt_d = fcnt_q + 2'd1;
            2'b01:   fcnt_d = fcnt_q - 2'd1;
            default: fcnt_d = fcnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            timer_q   <= '0;
            cnt_q     <= '0;
            pend_q    <= 1'b0;
            frame_q   <= '0;
            gen_en_q  <= 1'b0;
            data_q[0] <= '0;
            data_q[1] <= '0;
            last_q    <= '0;
            wr_q      <= 1'b0;
            rd_q      <= 1'b0;
            fcnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            cnt_q    <= cnt_d;
            pend_q   <= pend_d;
            frame_q  <= frame_d;
            gen_en_q <= (state_d == S_BURST);
            fcnt_q   <= fcnt_d;
            if (push) begin
                data_q[wr_q] <= gen_data;
                last_q[wr_q] <= burst_done;
                wr_q         <= ~wr_q;
            end
            if (pop) begin
                rd_q <= ~rd_q;
            end
        end
    end

    assign gen_enable = gen_en_q;
    assign busy       = (state_q != S_IDLE);
    assign frame_cnt  = frame_q;
    assign out_valid  = (fcnt_q != 2'd0);
    assign out_data   = out_valid ? data_q[rd_q] : '0;
    assign out_last   = out_valid & last_q[rd_q];

`ifdef IMU_BURST_CTRL_OVF_CNT_EN
    logic       drop;
    logic [7:0] ovf_q;

    assign drop = sample && (fcnt_q == 2'd2) && !pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= '0;
        end else if (drop && (ovf_q != 8'hFF)) begin
            ovf_q <= ovf_q + 8'd1;
        end
    end

    assign ovf_cnt = ovf_q;
`endif

endmodule

// File: tb/tb_imu_burst_ctrl.sv
// Directed bench for imu_burst_ctrl: expected samples are queued as they are driven
// and compared when the controller presents them downstream.
module tb_imu_burst_ctrl;

    localparam int DW = 16;
    localparam int BL = 16;
    localparam int PW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          stop;
    logic [PW-1:0] period;
    logic          gen_enable;
    logic [DW-1:0] gen_data;
    logic          gen_valid;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic          busy;
    logic [7:0]    frame_cnt;
`ifdef IMU_BURST_CTRL_OVF_CNT_EN
    logic [7:0]    ovf_cnt;
`endif

    imu_burst_ctrl #(
        .DATA_WIDTH(DW),
        .BURST_LEN (BL),
        .PERIOD_W  (PW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .period    (period),
        .gen_enable(gen_enable),
        .gen_data  (gen_data),
        .gen_valid (gen_valid),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy),
        .frame_cnt (frame_cnt)
`ifdef IMU_BURST_CTRL_OVF_CNT_EN
        ,
        .ovf_cnt   (ovf_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          l;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_gen_enable"}, 32'(gen_enable), 32'd0);
        chk({tag, "_busy"},       32'(busy),       32'd0);
        chk({tag, "_out_valid"},  32'(out_valid),  32'd0);
        chk({tag, "_out_data"},   32'(out_data),   32'd0);
        chk({tag, "_out_last"},   32'(out_last),   32'd0);
        chk({tag, "_frame_cnt"},  32'(frame_cnt),  32'd0);
`ifdef IMU_BURST_CTRL_OVF_CNT_EN
        chk({tag, "_ovf_cnt"},    32'(ovf_cnt),    32'd0);
`endif
    endtask

    // Handshake observed here sees the inputs that the coming rising edge will use.
    task automatic cycle();
        if (out_valid && out_ready) begin
            checks++;
            assert (q.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_output observed=%0h expected=none", out_data);
            end
            if (q.size() != 0) begin
                exp_t e;
                e = q.pop_front();
                chk("out_data", 32'(out_data), 32'(e.d));
                chk("out_last", 32'(out_last), 32'(e.l));
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push_exp(input logic [DW-1:0] d, input logic l);
        exp_t e;
        e.d = d;
        e.l = l;
        q.push_back(e);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        stop      = 1'b0;
        period    = '0;
        gen_data  = '0;
        gen_valid = 1'b0;
        out_ready = 1'b0;

        @(negedge clk);
        chk_reset_vals("reset");
        @(negedge clk);
        rst = 1'b0;
        cycle();

        // Long period: 16-sample bursts 40 cycles apart; stop at sample 5 of the fourth burst.
        period    = 16'd40;
        out_ready = 1'b1;
        gen_valid = 1'b1;
        gen_data  = DW'($urandom);
        start     = 1'b1;
        cycle();
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            for (int c = 0; c < 40; c++) begin
                if (k == 3 && c == 17) break;
                chk("p40_gen_enable", 32'(gen_enable), 32'(c < 16));
                chk("p40_busy", 32'(busy), 32'(!(k == 3 && c == 16)));
                if (c == 16) chk("p40_frame_cnt", 32'(frame_cnt), 32'(k + 1));
                gen_data = DW'($urandom);
                if (c < 16) push_exp(gen_data, c == 15);
                stop = (k == 3 && c == 5);
                cycle();
            end
        end
        chk("p40_idle_busy", 32'(busy), 32'd0);

        // Period shorter than a burst: exactly one WAIT cycle between bursts; stop in WAIT.
        period = 16'd4;
        start  = 1'b1;
        cycle();
        start = 1'b0;
        for (int b = 0; b < 2; b++) begin
            for (int c = 0; c < 17; c++) begin
                chk("p4_gen_enable", 32'(gen_enable), 32'(c < 16));
                chk("p4_busy", 32'(busy), 32'd1);
                if (c == 16) chk("p4_frame_cnt", 32'(frame_cnt), 32'(5 + b));
                gen_data = DW'($urandom);
                if (c < 16) push_exp(gen_data, c == 15);
                stop = (b == 1 && c == 16);
                cycle();
            end
        end
        stop = 1'b0;
        chk("wait_stop_busy", 32'(busy), 32'd0);
        chk("wait_stop_gen_enable", 32'(gen_enable), 32'd0);

        // Downstream stalled for a whole burst: two held, the rest dropped.
        period    = 16'd20;
        out_ready = 1'b0;
        start     = 1'b1;
        cycle();
        start = 1'b0;
        for (int c = 0; c < 16; c++) begin
            gen_data = DW'($urandom);
            if (c < 2) push_exp(gen_data, 1'b0);
            cycle();
        end
        chk("stall_frame_cnt", 32'(frame_cnt), 32'd7);
        chk("stall_out_valid", 32'(out_valid), 32'd1);
        chk("stall_out_data_held", 32'(out_data), 32'(q[0].d));
        chk("stall_out_last", 32'(out_last), 32'd0);
        chk("stall_gen_enable", 32'(gen_enable), 32'd0);
`ifdef IMU_BURST_CTRL_OVF_CNT_EN
        chk("stall_ovf_cnt", 32'(ovf_cnt), 32'd14);
`endif
        stop = 1'b1;
        cycle();
        stop = 1'b0;
        chk("stall_stop_busy", 32'(busy), 32'd0);
        out_ready = 1'b1;
        gen_valid = 1'b0;
        for (int i = 0; i < 3; i++) cycle();
        chk("stall_drained", 32'(q.size()), 32'd0);
        gen_valid = 1'b1;

        // Simultaneous start and stop in IDLE.
        start = 1'b1;
        stop  = 1'b1;
        cycle();
        start = 1'b0;
        stop  = 1'b0;
        chk("startstop_busy", 32'(busy), 32'd0);
        chk("startstop_gen_enable", 32'(gen_enable), 32'd0);
        cycle();
        chk("startstop_busy2", 32'(busy), 32'd0);

        // Reset mid-burst at sample 8 with the FIFO full.
        period    = 16'd40;
        out_ready = 1'b0;
        start     = 1'b1;
        cycle();
        start = 1'b0;
        for (int c = 0; c < 8; c++) begin
            gen_data = DW'($urandom);
            cycle();
        end
        chk("prerst_out_valid", 32'(out_valid), 32'd1);
        chk("prerst_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk_reset_vals("rst_async");
        @(negedge clk);
        chk_reset_vals("rst_held");
        rst       = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk("postrst_busy", 32'(busy), 32'd0);
            chk("postrst_gen_enable", 32'(gen_enable), 32'd0);
            chk("postrst_out_valid", 32'(out_valid), 32'd0);
            cycle();
        end

        // Normal burst after reset: sample count restarted from zero.
        period = 16'd20;
        start  = 1'b1;
        cycle();
        start = 1'b0;
        for (int c = 0; c < 17; c++) begin
            chk("after_rst_gen_enable", 32'(gen_enable), 32'(c < 16));
            if (c == 16) chk("after_rst_frame_cnt", 32'(frame_cnt), 32'd1);
            gen_data = DW'($urandom);
            if (c < 16) push_exp(gen_data, c == 15);
            stop = (c == 16);
            cycle();
        end
        stop = 1'b0;
        chk("after_rst_busy", 32'(busy), 32'd0);
        cycle();
        chk("final_drained", 32'(q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
